// File: rtl/cla_mp_add_seq_if.sv
// cla_mp_add_seq_if: host-side handshake and operand/result bundle for cla_mp_add_seq.
//   master (host):      drives start, sub, cin, a, b; observes ready, busy, done, result, cout, overflow
//   slave  (sequencer): the reverse
interface cla_mp_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 8 * WORDS;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    modport master(output start, sub, cin, a, b, input ready, busy, done, result, cout, overflow);
    modport slave(input start, sub, cin, a, b, output ready, busy, done, result, cout, overflow);
endinterface

// File: rtl/cla_mp_add_seq.sv
// cla_mp_add_seq: WORDS*8-bit add/subtract streamed LSB byte first through one 8-bit CLA.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport: start/sub/cin/a/b in; ready (IDLE), busy (RUN), done (one-cycle pulse),
//          result, cout (sub: 1 = no borrow), overflow (signed) out; results held until next start
module cla_mp_add_seq #(
    parameter int WORDS = 4
) (
    input logic             clk,
    input logic             rst_n,
    cla_mp_add_seq_if.slave bus
);
    localparam int W  = 8 * WORDS;
    localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [7:0]    la, lb, g, p, sum;
    logic [8:0]    c;
    logic          t, prod;

    // Limb CLA: each carry is a flat sum of products of generate/propagate terms
    // and the chained carry, so no carry ripples through the byte.
    always_comb begin
        la   = a_q[{cnt_q, 3'b000} +: 8];
        lb   = b_q[{cnt_q, 3'b000} +: 8];
        g    = la & lb;
        p    = la ^ lb;
        c    = '0;
        c[0] = carry_q;
        t    = 1'b0;
        prod = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t    = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t    = t | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = t | (prod & carry_q);
        end
        sum = p ^ c[7:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                a_d     = bus.a;
                // Subtraction is A + ~B + 1, so the inverted operand and forced carry are latched once.
                b_d     = bus.sub ? ~bus.b : bus.b;
                carry_d = bus.sub | bus.cin;
                cnt_d   = '0;
                res_d   = '0;
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
            end
            RUN: begin
                res_d[{cnt_q, 3'b000} +: 8] = sum;
                carry_d = c[8];
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = c[8];
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum[7] != a_q[W-1]);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ready    = state_q == IDLE;
    assign bus.busy     = state_q == RUN;
    assign bus.done     = state_q == DONE;
    assign bus.result   = res_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_cla_mp_add_seq.sv
// tb_cla_mp_add_seq: checks cla_mp_add_seq (WORDS=4 and WORDS=1) against an arithmetic timeline model.
module tb_cla_mp_add_seq;
    localparam int WORDS = 4;

    // t: -1 idle, 0..w-1 limbs already written, w = done cycle
    typedef struct {
        int          t;
        int          acc;
        logic [63:0] res;
        logic [63:0] pres;
        logic        cout;
        logic        pcout;
        logic        ovf;
        logic        povf;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   npass = 0;
    mdl_t m4 = '{-1, 0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    mdl_t m1 = '{-1, 0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    cla_mp_add_seq_if #(.WORDS(WORDS)) bus ();
    cla_mp_add_seq_if #(.WORDS(1)) bus1 ();

    cla_mp_add_seq #(.WORDS(WORDS)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    cla_mp_add_seq #(.WORDS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Plain arithmetic reference: unsigned sum/difference, borrow as a compare, overflow as a range test.
    function automatic mdl_t step(input mdl_t m, input int w, input logic st, input logic sb,
                                  input logic ci, input logic [63:0] a, input logic [63:0] b);
        mdl_t        n   = m;
        int          wb  = 8 * w;
        logic [63:0] msk = (64'd1 << wb) - 1;
        logic [63:0] s;
        longint      sa, sbv, tru, lim;
        if (n.t < 0) begin
            if (st) begin
                s       = sb ? (a & msk) - (b & msk) : (a & msk) + (b & msk) + 64'(ci);
                sa      = longint'(a & msk) - (a[wb-1] ? (longint'(1) << wb) : 0);
                sbv     = longint'(b & msk) - (b[wb-1] ? (longint'(1) << wb) : 0);
                tru     = sb ? sa - sbv : sa + sbv + longint'(ci);
                lim     = longint'(1) << (wb - 1);
                n.pres  = s & msk;
                n.pcout = sb ? (a & msk) >= (b & msk) : s[wb];
                n.povf  = tru >= lim || tru < -lim;
                n.t     = 0;
                n.res   = '0;
                n.cout  = 1'b0;
                n.ovf   = 1'b0;
                n.acc++;
            end
        end else if (n.t == w) begin
            n.t = -1;
        end else begin
            n.t++;
            if (n.t == w) begin
                n.res  = n.pres;
                n.cout = n.pcout;
                n.ovf  = n.povf;
            end
        end
        return n;
    endfunction

    function automatic mdl_t rst_m(input mdl_t m);
        mdl_t n = m;
        n.t    = -1;
        n.res  = '0;
        n.cout = 1'b0;
        n.ovf  = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m4 <= rst_m(m4);
        else m4 <= step(m4, WORDS, bus.start, bus.sub, bus.cin, 64'(bus.a), 64'(bus.b));

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m1 <= rst_m(m1);
        else m1 <= step(m1, 1, bus1.start, bus1.sub, bus1.cin, 64'(bus1.a), 64'(bus1.b));

    task automatic cmp(input mdl_t m, input int w, input logic rdy, input logic bsy, input logic dn,
                       input logic [63:0] res, input logic co, input logic ov, input string tg);
        logic [63:0] er;
        er = (m.t >= 0 && m.t < w) ? m.pres & ((64'd1 << (8 * m.t)) - 1) : m.res;
        chk({tg, "_ready"}, rdy, m.t < 0);
        chk({tg, "_busy"}, bsy, m.t >= 0 && m.t < w);
        chk({tg, "_done"}, dn, m.t == w);
        chk({tg, "_result"}, res, er);
        chk({tg, "_cout"}, co, m.cout);
        chk({tg, "_ovf"}, ov, m.ovf);
    endtask

    always @(negedge clk) begin
        cmp(m4, WORDS, bus.ready, bus.busy, bus.done, 64'(bus.result), bus.cout, bus.overflow, "w4");
        cmp(m1, 1, bus1.ready, bus1.busy, bus1.done, 64'(bus1.result), bus1.cout, bus1.overflow, "w1");
    end

    initial begin
        bus1.start = 1'b0;
        bus1.sub   = 1'b0;
        bus1.cin   = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        forever begin
            @(negedge clk);
            bus1.start = $urandom_range(0, 3) != 0;
            bus1.sub   = 1'($urandom);
            bus1.cin   = 1'($urandom);
            bus1.a     = 8'($urandom);
            bus1.b     = 8'($urandom);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c);
        @(negedge clk);
        chk("issue_ready", bus.ready, 1'b1);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        bus.cin   = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!bus.done && k < 4 * WORDS + 10) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Done is expected at the WORDS-th negedge after the negedge following the accepting edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c,
                          input logic [31:0] er, input logic ec, input logic eo, input string nm);
        int k;
        issue(a, b, s, c);
        wait_done(k);
        chk({nm, "_latency"}, 64'(k), 64'(WORDS));
        chk({nm, "_result"}, bus.result, er);
        chk({nm, "_cout"}, bus.cout, ec);
        chk({nm, "_ovf"}, bus.overflow, eo);
    endtask

    initial begin
        int k, acc0, nd;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_cout", bus.cout, 1'b0);
        chk("rst_ovf", bus.overflow, 1'b0);
        #1 rst_n = 1'b1;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, "carry_byte");
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, "full_ripple");
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "add_ovf");
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf");

        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(k);
        chk("ignored_start_done", bus.done, 1'b1);
        chk("ignored_start_result", bus.result, 32'h23456789);

        issue(32'h01010101, 32'h01010101, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_ready", bus.ready, 1'b1);
        chk("midrun_rst_busy", bus.busy, 1'b0);
        chk("midrun_rst_done", bus.done, 1'b0);
        chk("midrun_rst_result", bus.result, 32'h0);
        chk("midrun_rst_cout", bus.cout, 1'b0);
        chk("midrun_rst_ovf", bus.overflow, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.ready, 1'b1);
        run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, "neg_ovf");

        acc0 = m4.acc;
        nd   = 0;
        @(negedge clk);
        bus.start = 1'b1;
        repeat (200 * (WORDS + 2)) begin
            bus.a   = $urandom;
            bus.b   = $urandom;
            bus.sub = 1'($urandom);
            bus.cin = 1'($urandom);
            @(negedge clk);
            nd += int'(bus.done);
        end
        bus.start = 1'b0;
        chk("b2b_accepts", 64'(m4.acc - acc0), 64'd200);
        chk("b2b_done_pulses", 64'(nd), 64'd200);
        chk("w1_ops", 64'(m1.acc >= 200), 64'd1);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
